// File: rtl/tour_move_exec_if.sv
// Command/response bundle between a command issuer and the knight move executor.
// Pure wiring, no latency.
// Backpressure: cmd_rdy is held by the master until the slave pulses clr_cmd_rdy.
interface tour_move_exec_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        line_crossed;
    logic [7:0]  heading_cmd;
    logic        moving;
    logic [2:0]  xpos;
    logic [2:0]  ypos;
    logic        err;

    modport master (
        output cmd, cmd_rdy, line_crossed,
        input  clr_cmd_rdy, send_resp, heading_cmd, moving, xpos, ypos, err
    );

    modport slave (
        input  cmd, cmd_rdy, line_crossed,
        output clr_cmd_rdy, send_resp, heading_cmd, moving, xpos, ypos, err
    );
endinterface

// File: rtl/tour_move_exec.sv
// Executes calibrate/move commands and tracks a knight's square on a 5x5 board.
// Latency: calibrate CAL_CYC+2, zero-square move SETTLE_CYC+2 cycles from accept to send_resp.
// Backpressure: a command is only accepted (clr_cmd_rdy) in IDLE; otherwise cmd_rdy waits.
module tour_move_exec #(
    parameter logic [15:0] CAL_CYC    = 16'd2000,
    parameter logic [15:0] SETTLE_CYC = 16'd1000,
    parameter logic [23:0] TMO_CYC    = 24'd5_000_000,
    parameter logic [2:0]  START_X    = 3'd2,
    parameter logic [2:0]  START_Y    = 3'd2
) (
    input  logic             clk,
    input  logic             rst,
    tour_move_exec_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CAL, SETTLE, MOVE, RESP} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [23:0] tmr;
    logic [3:0]  sq_cnt;
    logic [3:0]  squares;
    logic [7:0]  heading;
    logic [2:0]  xpos, ypos;
    logic        err;

    logic [3:0]  opcode;
    logic        is_cal, is_move;
    logic        hdg_legal;
    logic [3:0]  sq_next;
    logic        last_pulse, tmo_hit;
    logic signed [5:0] mag, nx, ny;
    logic        pos_ok;

    assign opcode  = bus.cmd[15:12];
    assign is_cal  = (opcode == 4'h0);
    assign is_move = (opcode == 4'h2) || (opcode == 4'h3);

    assign hdg_legal  = (heading == 8'h00) || (heading == 8'h7F) ||
                        (heading == 8'h3F) || (heading == 8'hBF);
    assign sq_next    = sq_cnt + 4'd1;
    assign last_pulse = bus.line_crossed && (sq_next == squares);
    assign tmo_hit    = !bus.line_crossed && (tmr == TMO_CYC - 24'd1);

    // Candidate position, computed wide enough that no squares count can wrap back into range
    always_comb begin
        mag = $signed({2'b00, squares});
        nx  = $signed({3'b000, xpos});
        ny  = $signed({3'b000, ypos});
        case (heading)
            8'h00:   ny = $signed({3'b000, ypos}) + mag;
            8'h7F:   ny = $signed({3'b000, ypos}) - mag;
            8'h3F:   nx = $signed({3'b000, xpos}) - mag;
            8'hBF:   nx = $signed({3'b000, xpos}) + mag;
            default: ;
        endcase
        pos_ok = (nx >= 6'sd0) && (nx <= 6'sd4) && (ny >= 6'sd0) && (ny <= 6'sd4);
    end

    // Next-state decode plus the Mealy accept pulse and the response pulse
    always_comb begin
        state_nxt       = state;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_rdy) begin
                    bus.clr_cmd_rdy = 1'b1;
                    if (is_cal)       state_nxt = CAL;
                    else if (is_move) state_nxt = SETTLE;
                    else              state_nxt = RESP;
                end
            end
            CAL:    if (cnt == CAL_CYC) state_nxt = RESP;
            SETTLE: begin
                if (cnt == SETTLE_CYC) begin
                    if (squares == 4'd0 || !hdg_legal) state_nxt = RESP;
                    else                               state_nxt = MOVE;
                end
            end
            MOVE:   if (last_pulse || tmo_hit) state_nxt = RESP;
            RESP: begin
                bus.send_resp = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Command latch, cycle counters, position and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            tmr     <= '0;
            sq_cnt  <= '0;
            squares <= '0;
            heading <= 8'h00;
            xpos    <= START_X;
            ypos    <= START_Y;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_rdy) begin
                        squares <= bus.cmd[3:0];
                        cnt     <= '0;
                        if (is_move)               heading <= bus.cmd[11:4];
                        else if (!is_cal)          err     <= 1'b1;
                    end
                end
                CAL: begin
                    if (cnt == CAL_CYC) begin
                        cnt <= '0;
                        err <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_CYC) begin
                        cnt    <= '0;
                        tmr    <= '0;
                        sq_cnt <= '0;
                        if (!hdg_legal) err <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                MOVE: begin
                    if (bus.line_crossed) begin
                        sq_cnt <= sq_next;
                        tmr    <= '0;
                        if (last_pulse) begin
                            if (pos_ok) begin
                                xpos <= nx[2:0];
                                ypos <= ny[2:0];
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end else if (tmo_hit) begin
                        err <= 1'b1;
                    end else begin
                        tmr <= tmr + 24'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.heading_cmd = heading;
    assign bus.moving      = (state == MOVE);
    assign bus.xpos        = xpos;
    assign bus.ypos        = ypos;
    assign bus.err         = err;

endmodule
